fifo_key_seg_top: RTL and testbench
===================================

Name: fifo_key_seg_top

Overview:
Demo top level that exercises an on-chip FIFO from a push-button and shows results on LEDs and a multiplexed 7-segment display. A debounced key press fills the FIFO with a counting pattern, then drains it at a slow, visible rate. Each word read is shown as two hex digits. Single clock domain (nominal 50 MHz).

Parameters:
DATA_W, 8, FIFO word width
DEPTH, 16, FIFO depth in words (power of two)
DEBOUNCE_CYCLES, 1_000_000, cycles key must be stable low to register a press (20 ms)
READ_INTERVAL, 25_000_000, cycles between successive reads in read phase (0.5 s)
SCAN_CYCLES, 50_000, cycles per display digit (1 ms)
DIGITS, 6, number of scanned digit positions

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous, active-high reset; the port keeps the codebase name rst_n, but asserting it high resets the block
key  input  1  raw push-button, active-low, asynchronous/bouncy
led_wr  output  1  high while FSM in WRITE
led_rd  output  1  high while FSM in READ
sel  output  3  binary index of currently driven digit, 0..DIGITS-1
seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}; dp always off (bit7=1)

Behaviour:
- Reset (rst_n=1 at a clk edge) clears all state: FSM=IDLE, FIFO empty, counters 0, display value 0.
- Reset output values: led_wr=0, led_rd=0, sel=0, seg=8'hFF.
- Key input passes through a 2-flop synchronizer.
- Debounce: a counter increments while the synced key=0 and clears when key=1.
- A single-cycle press pulse fires when the debounce counter reaches DEBOUNCE_CYCLES-1. At most one pulse per continuous hold; key must return high before the next press.
- FSM states IDLE, WRITE, READ:
  - IDLE: on press pulse -> WRITE, write index cleared.
  - WRITE: one write per cycle, data = write index (0,1,2..), index increments. When the FIFO reports full (after DEPTH writes) -> READ, interval counter cleared.
  - READ: interval counter counts to READ_INTERVAL-1, then one read is issued and the counter wraps. When the FIFO reports empty with no read in flight -> IDLE.
  - Press pulses outside IDLE are ignored.
- FIFO (sync, registered output): write ignored when full; read ignored when empty.
  - Simultaneous read and write keeps the count unchanged.
  - Pointers are log2(DEPTH)+1 bits. Full = MSBs differ and the rest are equal; empty = pointers equal.
  - rd_data is valid the cycle after rd_en.
- Display value register loads rd_data the cycle after a read; it holds through IDLE and the next WRITE.
- Display scan: counter to SCAN_CYCLES-1, then sel advances 0..DIGITS-1 and wraps to 0.
  - sel=0: low nibble, sel=1: high nibble, as hex glyphs 0-F.
  - Other positions are blank (8'hFF).
  - Glyphs, active-low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Reset mid-operation aborts the operation; FIFO contents are discarded.

Decomposition:
- Shared package holds: the state enum (IDLE/WRITE/READ), the 16-entry hex-to-segment constant table, and the blank code 8'hFF.
- One natural sub-module: fifo_sync_core, parameterized by DATA_W and DEPTH. Ports: wr_en, wr_data, rd_en, rd_data, full, empty.
- Debounce, FSM and scan stay in the top.

Test Plan:
Use small parameters in the bench: DEBOUNCE_CYCLES=8, READ_INTERVAL=4, SCAN_CYCLES=2, DEPTH=16.
- Reset: hold rst_n=1 for 2 cycles -> led_wr=0, led_rd=0, sel=0, seg=FF; sel then scans 0..5 with digit 0 = C0 (value 00).
- Bounce: key low for 5 cycles, high, then low for 5 -> no press; led_wr stays 0.
- Press: key low for 20 cycles -> one pulse; led_wr=1 for exactly 16 cycles; full asserts; then led_rd=1.
- Read phase: reads every 4 cycles give display values 00,01..0F in order. For value 0x0A, sel=0 shows 88 and sel=1 shows C0. After 16 reads, empty -> IDLE, led_rd=0, display holds 0F.
- Ignore press: a second key press during READ does not change state or read order. A press after returning to IDLE restarts WRITE.
- Mid-operation reset: rst_n=1 during WRITE at index 7 -> immediate IDLE, LEDs 0, FIFO empty, seg=FF.

Source files
------------

// File: rtl/fifo_key_seg_pkg.sv
// Shared state type and 7-segment constants for the FIFO key demo.
// Latency: n/a (types, constants and one pure lookup function).
// Backpressure: n/a.
package fifo_key_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is kept off in every glyph.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry n is the glyph for hex digit n (index 0 sits in the low byte).
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/fifo_sync_core.sv
// Single-clock FIFO with registered read data and extra-MSB wrap pointers.
// Latency: rd_data valid one cycle after an accepted rd_en.
// Backpressure: writes dropped while full, reads dropped while empty.
module fifo_sync_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_fire, rd_fire;

  // Same slot, opposite lap -> full; identical pointers -> empty.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = rd_data_q;

  // Pointer and read-data registers; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_fire) begin
        rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
        rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  // Storage needs no reset: the pointers alone define which words are live.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fifo_key_seg_top.sv
// Key-triggered FIFO fill/drain demo driving LEDs and a scanned 7-segment display.
// Latency: press pulse DEBOUNCE_CYCLES-1 synced cycles after key goes low; display updates 2 cycles after a read.
// Backpressure: writing stops on FIFO full; reads are paced by READ_INTERVAL and stop on empty.
module fifo_key_seg_top
  import fifo_key_seg_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int DEPTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int READ_INTERVAL   = 25_000_000,
  parameter int SCAN_CYCLES     = 50_000,
  parameter int DIGITS          = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  output logic       led_wr,
  output logic       led_rd,
  output logic [2:0] sel,
  output logic [7:0] seg
);

  localparam int AW   = $clog2(DEPTH);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int RI_W = $clog2(READ_INTERVAL);
  localparam int SC_W = $clog2(SCAN_CYCLES);

  localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RI_W-1:0] RI_MAX   = RI_W'(READ_INTERVAL - 1);
  localparam logic [SC_W-1:0] SC_MAX   = SC_W'(SCAN_CYCLES - 1);
  localparam logic [2:0]      SEL_MAX  = 3'(DIGITS - 1);
  localparam logic [AW-1:0]   IDX_LAST = AW'(DEPTH - 1);

  // rst_n is active-high despite its name.
  logic              key_s1_q, key_s2_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              press_q, press_d;
  state_e            state_q, state_d;
  logic [AW-1:0]     wr_idx_q, wr_idx_d;
  logic [RI_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic              rd_pend_q;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic [SC_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [2:0]        sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;
  logic [7:0]        disp_byte;

  logic              fifo_wr_en, fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full, fifo_empty;

  fifo_sync_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst_n),
    .wr_en   (fifo_wr_en),
    .wr_data (DATA_W'(wr_idx_q)),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Debounce: count synced-low cycles, saturate, and pulse once on first reaching the limit.
  always_comb begin
    db_cnt_d = db_cnt_q;
    press_d  = 1'b0;
    if (key_s2_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q != DB_MAX) begin
      db_cnt_d = db_cnt_q + DB_W'(1);
      press_d  = (db_cnt_d == DB_MAX);
    end
  end

  // Sequencer: IDLE waits for a press, WRITE fills with the index pattern, READ drains at a slow pace.
  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_cnt_d   = rd_cnt_q;
    fifo_wr_en = 1'b0;
    fifo_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_q) begin
          state_d  = ST_WRITE;
          wr_idx_d = '0;
        end
      end
      ST_WRITE: begin
        fifo_wr_en = !fifo_full;
        if (fifo_wr_en) wr_idx_d = wr_idx_q + AW'(1);
        // Leave together with the write that fills the FIFO, so LED-on time equals DEPTH writes.
        if (fifo_full || (fifo_wr_en && wr_idx_q == IDX_LAST)) begin
          state_d  = ST_READ;
          rd_cnt_d = '0;
        end
      end
      ST_READ: begin
        if (rd_cnt_q == RI_MAX) begin
          rd_cnt_d   = '0;
          fifo_rd_en = !fifo_empty;
        end else begin
          rd_cnt_d = rd_cnt_q + RI_W'(1);
        end
        if (fifo_empty && !rd_pend_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Display: capture read data once valid, rotate digit select, and register the segment pattern
  // from next-state values so seg always matches the sel and value presented alongside it.
  always_comb begin
    disp_d     = rd_pend_q ? fifo_rd_data : disp_q;
    scan_cnt_d = scan_cnt_q + SC_W'(1);
    sel_d      = sel_q;
    if (scan_cnt_q == SC_MAX) begin
      scan_cnt_d = '0;
      sel_d      = (sel_q == SEL_MAX) ? 3'd0 : sel_q + 3'd1;
    end
    disp_byte = 8'(disp_d);
    case (sel_d)
      3'd0:    seg_d = hex_to_seg(disp_byte[3:0]);
      3'd1:    seg_d = hex_to_seg(disp_byte[7:4]);
      default: seg_d = SEG_BLANK;
    endcase
  end

  // All state registers; reset aborts any fill/drain in progress.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      key_s1_q   <= 1'b1;
      key_s2_q   <= 1'b1;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      state_q    <= ST_IDLE;
      wr_idx_q   <= '0;
      rd_cnt_q   <= '0;
      rd_pend_q  <= 1'b0;
      disp_q     <= '0;
      scan_cnt_q <= '0;
      sel_q      <= 3'd0;
      seg_q      <= SEG_BLANK;
    end else begin
      key_s1_q   <= key;
      key_s2_q   <= key_s1_q;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_pend_q  <= fifo_rd_en && !fifo_empty;
      disp_q     <= disp_d;
      scan_cnt_q <= scan_cnt_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign led_wr = (state_q == ST_WRITE);
  assign led_rd = (state_q == ST_READ);
  assign sel    = sel_q;
  assign seg    = seg_q;

endmodule

// File: tb/tb_fifo_key_seg_top.sv
// Randomized bench: key timing is random; display, scan and LED behaviour are predicted from
// elapsed-cycle arithmetic (scan position from cycles since reset, shown value from cycles since READ began).
// Backpressure: n/a.
module tb_fifo_key_seg_top;

  localparam int RI    = 4;
  localparam int NWORD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key = 1'b1;
  logic       led_wr, led_rd;
  logic [2:0] sel;
  logic [7:0] seg;

  int n_chk = 0;
  int n_bad = 0;
  int key_left = 0;

  int k = 0;
  bit rst_seen = 1'b0;
  int rk = 0;
  bit rk_valid = 1'b0;
  bit prev_rd = 1'b0;
  int exp_disp = 0;
  int exp_sel = 0;
  int m = 0;
  logic [7:0] exp_seg;

  fifo_key_seg_top #(
    .DATA_W          (8),
    .DEPTH           (16),
    .DEBOUNCE_CYCLES (8),
    .READ_INTERVAL   (RI),
    .SCAN_CYCLES     (2),
    .DIGITS          (6)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key    (key),
    .led_wr (led_wr),
    .led_rd (led_rd),
    .sel    (sel),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input int n);
    case (n)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
      12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (key_left > 0) begin
      key_left--;
      if (key_left == 0) key = 1'b1;
    end
  endtask

  task automatic press(input int n);
    key = 1'b0;
    key_left = n;
  endtask

  // Cycles since the last reset edge: 0 on the cycle right after a reset edge.
  always @(posedge clk) begin
    if (rst_n) begin
      k <= 0;
      rst_seen <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  // Every-cycle scan/display checker driven purely by elapsed-time arithmetic.
  always @(negedge clk) begin
    if (rst_seen) begin
      if (k == 0) begin
        exp_disp = 0;
        rk_valid = 1'b0;
        check_val("rst_led_wr", 32'(led_wr), 0);
        check_val("rst_led_rd", 32'(led_rd), 0);
        check_val("rst_sel", 32'(sel), 0);
        check_val("rst_seg", 32'(seg), 32'hFF);
      end else begin
        if (led_rd && !prev_rd) begin
          rk = k;
          rk_valid = 1'b1;
        end
        // Read j issues RI*(j+1)-1 cycles into READ and becomes visible two cycles later.
        if (rk_valid && k >= rk + RI + 1) begin
          m = (k - rk - 1) / RI;
          if (m > NWORD) m = NWORD;
          exp_disp = m - 1;
        end
        exp_sel = (k / 2) % 6;
        if (exp_sel == 0)      exp_seg = glyph(exp_disp % 16);
        else if (exp_sel == 1) exp_seg = glyph(exp_disp / 16);
        else                   exp_seg = 8'hFF;
        check_val("scan_sel", 32'(sel), 32'(exp_sel));
        check_val("scan_seg", 32'(seg), 32'(exp_seg));
        check_val("led_exclusive", 32'(led_wr && led_rd), 0);
      end
      prev_rd = led_rd;
    end
  end

  task automatic run_round(input bit ignore_press);
    int t, w, r, ig_at;
    press(20);
    t = 0;
    while (!led_wr && t < 40) begin step(); t++; end
    check_val("press_to_write", 32'(led_wr), 1);
    w = 0;
    while (led_wr && w < 40) begin w++; step(); end
    check_val("write_cycles", 32'(w), NWORD);
    check_val("read_entered", 32'(led_rd), 1);
    check_val("fifo_full_at_read", 32'(dut.fifo_full), 1);
    ig_at = $urandom_range(3, 28);
    r = 0;
    while (led_rd && r < 200) begin
      if (ignore_press && r == ig_at) press(20);
      step();
      r++;
      check_val("no_write_in_read", 32'(led_wr), 0);
    end
    check_val("read_span", 32'(r >= NWORD*RI && r <= NWORD*RI + 4), 1);
    check_val("idle_led_rd", 32'(led_rd), 0);
    check_val("fifo_empty_idle", 32'(dut.fifo_empty), 1);
    t = 0;
    while (key_left > 0 && t < 40) begin step(); t++; end
    t = 0;
    while (sel != 3'd0 && t < 20) begin step(); t++; end
    check_val("hold_lo_0F", 32'(seg), 32'h8E);
    t = 0;
    while (sel != 3'd1 && t < 20) begin step(); t++; end
    check_val("hold_hi_0F", 32'(seg), 32'hC0);
    repeat ($urandom_range(8, 30)) step();
    check_val("still_idle", 32'(led_wr || led_rd), 0);
  endtask

  initial begin
    bit saw;
    int t;
    step();
    step();
    check_val("init_led_wr", 32'(led_wr), 0);
    check_val("init_led_rd", 32'(led_rd), 0);
    check_val("init_sel", 32'(sel), 0);
    check_val("init_seg", 32'(seg), 32'hFF);
    rst_n = 1'b0;
    repeat (16) step();

    // Bounce: short low bursts separated by high glitches never reach the debounce limit.
    saw = 1'b0;
    repeat (3) begin
      key = 1'b0;
      repeat ($urandom_range(1, 5)) begin step(); saw |= led_wr; end
      key = 1'b1;
      repeat ($urandom_range(1, 3)) begin step(); saw |= led_wr; end
    end
    repeat (16) begin step(); saw |= led_wr; end
    check_val("bounce_no_press", 32'(saw), 0);

    run_round(1'b0);
    run_round(1'b1);

    // Abort during WRITE at index 7.
    press(20);
    t = 0;
    while (!led_wr && t < 40) begin step(); t++; end
    check_val("mid_write_started", 32'(led_wr), 1);
    repeat (7) step();
    key = 1'b1;
    key_left = 0;
    rst_n = 1'b1;
    step();
    check_val("mid_rst_led_wr", 32'(led_wr), 0);
    check_val("mid_rst_led_rd", 32'(led_rd), 0);
    check_val("mid_rst_seg", 32'(seg), 32'hFF);
    check_val("mid_rst_empty", 32'(dut.fifo_empty), 1);
    rst_n = 1'b0;
    repeat (20) step();
    check_val("mid_no_restart", 32'(led_wr), 0);

    run_round(1'b1);
    run_round(1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
